gol_board_stepper: RTL
======================

Name: gol_board_stepper

Overview:
Holds the Game of Life board as a register array and advances it one generation per request. Evaluates one row per clock: every column of the current row forms its 8-neighbour byte, feeds a bit_counter, and applies the Conway rule. Sits directly upstream of bit_counter, which it instantiates, and produces the board image for display/readout logic.

Parameters:
ROWS, 8, board height; must be >= 3
COLS, 8, board width; must be >= 3
WRAP, 1, 1 = toroidal edges; 0 = off-board neighbours read as dead
GEN_W, 16, generation counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load  in  1  copy load_cells into board (honoured in IDLE only)
load_cells  in  ROWS*COLS  board image to load; cell (r,c) at bit r*COLS+c
step_req  in  1  request one generation (honoured in IDLE only)
busy  out  1  high while a generation is in progress
done  out  1  one-cycle pulse; cells already holds the new generation
cells  out  ROWS*COLS  current board, registered
generation  out  GEN_W  generations since last load/reset, wraps modulo 2^GEN_W
changed  out  1  last committed step altered at least one cell
all_dead  out  1  combinational: cells == 0

Behaviour:
- Reset (async, any state): cells=0, generation=0, busy=0, done=0, changed=0, state=S_IDLE, row_ptr=0, next buffer discarded; all_dead=1.
- States: S_IDLE, S_COMPUTE, S_COMMIT.
- S_IDLE: load has priority over step_req. On load: cells<=load_cells, generation<=0, changed<=0, stay IDLE. Else on step_req: row_ptr<=0, busy<=1, go S_COMPUTE.
- S_COMPUTE: each edge writes next-row[row_ptr] from the unchanged cells array, row_ptr++. The edge processing row_ptr=ROWS-1 goes to S_COMMIT.
- S_COMMIT edge: cells<=next, generation<=generation+1, changed<=(next!=cells), done<=1, busy<=0, go S_IDLE. done clears on the following edge.
- Latency: step_req sampled at edge E0. Rows are computed at edges E1..E_ROWS. Commit occurs at E_ROWS+1. done and new cells are visible in the cycle after E_ROWS+1. busy is high from E0 to E_ROWS+1.
- load and step_req outside S_IDLE are ignored, not queued. A request may be issued in the same cycle done is high, because state is already IDLE.
- Rule: count = bit_counter(neighbours), range 0..8. next = (count==3) | (alive & count==2).
- Neighbour byte order: NW,N,NE,W,E,SW,S,SE mapped to bits 7..0. Order is irrelevant to the count but fixed for waveform readability.
- WRAP=1: row/col indices wrap modulo ROWS/COLS. WRAP=0: out-of-range neighbours are 0.
- generation wraps from 2^GEN_W-1 to 0 with no flag.

Decomposition:
- gol_pkg: state enum (S_IDLE, S_COMPUTE, S_COMMIT); BIRTH_COUNT=3, SURVIVE_COUNT=2; neighbour bit-position constants.
- Sub-module gol_cell_rule: inputs are alive and an 8-bit neighbour byte; output is next alive. It wraps one bit_counter. COLS instances are used in a generate loop. Row/neighbour muxing and the FSM stay in gol_board_stepper.

Test Plan:
1. Reset mid-S_COMPUTE (row_ptr=4) after loading a blinker -> cells=0, busy=0, generation=0, all_dead=1, done never pulses.
2. 8x8 WRAP=1: load horizontal blinker at row 3, cols 2..4; step -> vertical at col 3, rows 2..4. done is seen exactly 9 edges after step_req sampling; generation=1, changed=1. A second step restores the original, generation=2.
3. Load a 2x2 block at (2,2)..(3,3); step -> cells unchanged, changed=0, generation=1.
4. Corner pattern (7,7),(7,0),(0,7): with WRAP=1, step -> (0,0) is born, forming a block across the corner. With WRAP=0, step -> all cells die, all_dead=1.
5. During busy, pulse load (load_cells all ones) and step_req -> both ignored, and the result equals test 2. In IDLE, assert load and step_req together -> load wins, busy stays 0, generation=0.
6. GEN_W=2, blinker: 4 steps -> generation sequence 1,2,3,0.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life board stepper.
//   state_t       : stepper FSM states
//   BIRTH_COUNT   : neighbour count that brings a dead cell to life
//   SURVIVE_COUNT : extra neighbour count that keeps a live cell alive
//   NB_*          : bit position of each neighbour in the 8-bit neighbour byte
package gol_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam logic [3:0] BIRTH_COUNT   = 4'd3;
    localparam logic [3:0] SURVIVE_COUNT = 4'd2;

    localparam int NB_NW = 7;
    localparam int NB_N  = 6;
    localparam int NB_NE = 5;
    localparam int NB_W  = 4;
    localparam int NB_E  = 3;
    localparam int NB_SW = 2;
    localparam int NB_S  = 1;
    localparam int NB_SE = 0;

endpackage

// File: rtl/bit_counter.sv
// Population count of an 8-bit vector.
//   bits  : input vector
//   count : number of set bits, 0..8
module bit_counter (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'd0, bits[i]};
        end
    end

endmodule

// File: rtl/gol_cell_rule.sv
// Conway rule for one cell.
//   alive      : current state of the cell
//   neighbours : 8-neighbour byte (NW,N,NE,W,E,SW,S,SE on bits 7..0)
//   next_alive : state of the cell in the next generation
module gol_cell_rule
    import gol_pkg::*;
(
    input  logic       alive,
    input  logic [7:0] neighbours,
    output logic       next_alive
);

    logic [3:0] count;

    bit_counter u_count (
        .bits  (neighbours),
        .count (count)
    );

    assign next_alive = (count == BIRTH_COUNT) || (alive && (count == SURVIVE_COUNT));

endmodule

// File: rtl/gol_board_stepper.sv
// Game of Life board register with a row-serial generation stepper.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : copy load_cells into the board (IDLE only, wins over step_req)
//   load_cells : board image, cell (r,c) at bit r*COLS+c
//   step_req   : compute one generation (IDLE only)
//   busy       : generation in progress
//   done       : one-cycle pulse once cells holds the new generation
//   cells      : current board
//   generation : generations since last load/reset, wraps
//   changed    : last committed step altered at least one cell
//   all_dead   : cells == 0
//
// state     | meaning
// S_IDLE    | waiting for load or step_req
// S_COMPUTE | one row of the next board per clock, row_ptr = row being built
// S_COMMIT  | next board copied into cells, done raised
module gol_board_stepper
    import gol_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WRAP  = 1,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] load_cells,
    input  logic                 step_req,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] cells,
    output logic [GEN_W-1:0]     generation,
    output logic                 changed,
    output logic                 all_dead
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    state_t               state, state_next;
    logic [RW-1:0]        row_ptr;
    logic [ROWS*COLS-1:0] next_cells;
    logic                 do_load, do_start, do_row, do_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_start   = 1'b0;
        do_row     = 1'b0;
        do_commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    do_load = 1'b1;
                end else if (step_req) begin
                    do_start   = 1'b1;
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                do_row = 1'b1;
                if (row_ptr == LAST_ROW) state_next = S_COMMIT;
            end
            S_COMMIT: begin
                do_commit  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Neighbour rows of the row being computed; off-board rows read as dead
    // when the board does not wrap.
    logic [RW-1:0]   up_ptr, dn_ptr;
    logic            up_ok, dn_ok;
    logic [COLS-1:0] row_up, row_mid, row_dn, row_next;

    always_comb begin
        up_ptr  = (row_ptr == '0) ? LAST_ROW : row_ptr - 1'b1;
        dn_ptr  = (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
        up_ok   = (WRAP != 0) || (row_ptr != '0);
        dn_ok   = (WRAP != 0) || (row_ptr != LAST_ROW);
        row_mid = cells[row_ptr*COLS +: COLS];
        row_up  = up_ok ? cells[up_ptr*COLS +: COLS] : '0;
        row_dn  = dn_ok ? cells[dn_ptr*COLS +: COLS] : '0;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int  CL    = (c == 0) ? COLS - 1 : c - 1;
        localparam int  CR    = (c == COLS - 1) ? 0 : c + 1;
        localparam bit  CL_OK = (WRAP != 0) || (c != 0);
        localparam bit  CR_OK = (WRAP != 0) || (c != COLS - 1);
        logic [7:0] nb;

        always_comb begin
            nb        = 8'd0;
            nb[NB_NW] = CL_OK ? row_up[CL] : 1'b0;
            nb[NB_N]  = row_up[c];
            nb[NB_NE] = CR_OK ? row_up[CR] : 1'b0;
            nb[NB_W]  = CL_OK ? row_mid[CL] : 1'b0;
            nb[NB_E]  = CR_OK ? row_mid[CR] : 1'b0;
            nb[NB_SW] = CL_OK ? row_dn[CL] : 1'b0;
            nb[NB_S]  = row_dn[c];
            nb[NB_SE] = CR_OK ? row_dn[CR] : 1'b0;
        end

        gol_cell_rule u_rule (
            .alive      (row_mid[c]),
            .neighbours (nb),
            .next_alive (row_next[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells      <= '0;
            next_cells <= '0;
            generation <= '0;
            changed    <= 1'b0;
            done       <= 1'b0;
            row_ptr    <= '0;
        end else begin
            done <= do_commit;
            if (do_load) begin
                cells      <= load_cells;
                generation <= '0;
                changed    <= 1'b0;
            end
            if (do_start) row_ptr <= '0;
            if (do_row) begin
                next_cells[row_ptr*COLS +: COLS] <= row_next;
                row_ptr <= row_ptr + 1'b1;
            end
            if (do_commit) begin
                cells      <= next_cells;
                generation <= generation + 1'b1;
                changed    <= (next_cells != cells);
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign all_dead = (cells == '0);

endmodule
